// File: rtl/xbar_write_order_tracker_if.sv
// Handshake bundle between the crossbar AW/W datapath and the write-order tracker.
interface xbar_write_order_tracker_if #(
   parameter int unsigned masters       = 2,
   parameter int unsigned LEN_WIDTH     = 4,
   parameter int unsigned pending_depth = 8
);
   localparam int unsigned MW = $clog2(masters);
   localparam int unsigned CW = $clog2(pending_depth + 1);

   // address-grant side
   logic                 aw_push_valid;
   logic [MW-1:0]        aw_push_master;
   logic [LEN_WIDTH-1:0] aw_push_len;
   logic                 aw_push_ready;

   // write-data steering side
   logic                 w_src_valid;
   logic [MW-1:0]        w_src_master;
   logic                 w_beat_fire;
   logic                 w_beat_last;
   logic                 w_expect_last;

   // status
   logic                 len_error;
   logic [CW-1:0]        outstanding_count;
   logic                 idle;

   // datapath / arbiter side driving the tracker
   modport master (
      output aw_push_valid, aw_push_master, aw_push_len,
      output w_beat_fire, w_beat_last,
      input  aw_push_ready, w_src_valid, w_src_master, w_expect_last,
      input  len_error, outstanding_count, idle
   );

   // tracker side
   modport slave (
      input  aw_push_valid, aw_push_master, aw_push_len,
      input  w_beat_fire, w_beat_last,
      output aw_push_ready, w_src_valid, w_src_master, w_expect_last,
      output len_error, outstanding_count, idle
   );
endinterface

// File: rtl/xbar_write_order_tracker.sv
// Per-slave write-order tracker: remembers granted AW {master, len} in grant
// order and steers W beats from the head master, retiring bursts by beat count.
module xbar_write_order_tracker #(
   parameter int unsigned masters       = 2,
   parameter int unsigned LEN_WIDTH     = 4,
   parameter int unsigned pending_depth = 8
) (
   input logic                     ACLK,
   input logic                     ARESETn,
   xbar_write_order_tracker_if.slave bus
);
   localparam int unsigned MW = $clog2(masters);
   localparam int unsigned CW = $clog2(pending_depth + 1);
   localparam int unsigned PW = $clog2(pending_depth);

   typedef struct packed {
      logic [MW-1:0]        master;
      logic [LEN_WIDTH-1:0] len;
   } entry_t;

   entry_t               mem_q [pending_depth];
   entry_t               mem_d [pending_depth];
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [LEN_WIDTH-1:0] beat_q, beat_d;
   logic                 len_error_q, len_error_d;

   logic                 empty_c;
   logic                 full_c;
   logic                 expect_last_c;
   entry_t               head_c;
   logic                 push_ok_c;
   logic                 push_drop_c;
   logic                 fire_ok_c;
   logic                 fire_stray_c;
   logic                 pop_c;
   logic                 last_err_c;

   // Occupancy and head decode, all from registered state (no pop->push bypass).
   always_comb begin
      empty_c       = (count_q == '0);
      full_c        = (count_q == CW'(pending_depth));
      head_c        = mem_q[rd_ptr_q];
      expect_last_c = ~empty_c & (beat_q == head_c.len);
      push_ok_c     = bus.aw_push_valid & ~full_c;
      push_drop_c   = bus.aw_push_valid & full_c;
      fire_ok_c     = bus.w_beat_fire & ~empty_c;
      fire_stray_c  = bus.w_beat_fire & empty_c;
      pop_c         = fire_ok_c & expect_last_c;
      last_err_c    = fire_ok_c & (bus.w_beat_last != expect_last_c);
   end

   // Next state: FIFO pointers/count, beat counter, error pulse.
   always_comb begin
      mem_d       = mem_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      beat_d      = beat_q;
      len_error_d = push_drop_c | fire_stray_c | last_err_c;

      if (push_ok_c) begin
         mem_d[wr_ptr_q] = '{master: bus.aw_push_master, len: bus.aw_push_len};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end

      // Completion is by count; WLAST only feeds the error check.
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         beat_d   = '0;
      end else if (fire_ok_c) begin
         beat_d = beat_q + LEN_WIDTH'(1);
      end

      count_d = count_q + CW'(push_ok_c) - CW'(pop_c);
   end

   // State registers with asynchronous clear.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < int'(pending_depth); i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         beat_q      <= '0;
         len_error_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         beat_q      <= beat_d;
         len_error_q <= len_error_d;
      end
   end

   // Outputs; master is forced to 0 when nothing is pending.
   assign bus.aw_push_ready     = ~full_c;
   assign bus.w_src_valid       = ~empty_c;
   assign bus.w_src_master      = empty_c ? '0 : head_c.master;
   assign bus.w_expect_last     = expect_last_c;
   assign bus.len_error         = len_error_q;
   assign bus.outstanding_count = count_q;
   assign bus.idle              = empty_c;
endmodule

// File: doc/xbar_write_order_tracker.md
XBAR_WRITE_ORDER_TRACKER -- requirements
Module: xbar_write_order_tracker

Interface
REQ-001 SHALL have parameter masters, default 2, number of crossbar masters (>=2).
REQ-002 SHALL have parameter LEN_WIDTH, default 4, AXI burst-length field width.
REQ-003 SHALL have parameter pending_depth, default 8, outstanding write bursts tracked per slave port (power of two, >=2).
REQ-004 SHALL derive MW = $clog2(masters) and CW = $clog2(pending_depth+1).
REQ-005 ACLK  in  1  single clock; all state updates on the rising edge.
REQ-006 ARESETn  in  1  asynchronous, active-low reset.
REQ-007 aw_push_valid  in  1  write address granted and pushed into the slave AW FIFO this cycle.
REQ-008 aw_push_master  in  MW  granted master number for that address.
REQ-009 aw_push_len  in  LEN_WIDTH  AWLEN of that address.
REQ-010 aw_push_ready  out  1  order FIFO can take an entry; the write-address arbiter stalls when low.
REQ-011 w_src_valid  out  1  head burst active; write data may be forwarded.
REQ-012 w_src_master  out  MW  master whose W beats are forwarded.
REQ-013 w_beat_fire  in  1  one W beat moved from w_src_master into the slave W FIFO.
REQ-014 w_beat_last  in  1  WLAST of the firing beat.
REQ-015 w_expect_last  out  1  next firing beat completes the head burst by count.
REQ-016 len_error  out  1  one-cycle protocol-error pulse.
REQ-017 outstanding_count  out  CW  number of entries in the order FIFO.
REQ-018 idle  out  1  order FIFO empty.

Function
REQ-019 SHALL hold up to pending_depth entries {master, len}, pushed in aw_push_valid order.
- Write data leaves strictly in address-grant order.
- Any number of bursts from different masters may be outstanding.
REQ-020 Push rules:
- aw_push_ready = ~full; it is registered-state derived, with no same-cycle bypass from a pop.
- A push with aw_push_ready low SHALL be dropped with no state change and SHALL pulse len_error.
REQ-021 Head outputs: w_src_valid = ~empty, and w_src_master = head master.
- An entry pushed into an empty FIFO SHALL appear at the head on the next cycle (latency 1).
REQ-022 The beat counter (LEN_WIDTH bits) SHALL reset to 0 and increment on each w_beat_fire while w_src_valid.
- w_expect_last = w_src_valid & (beat counter == head len).
REQ-023 Burst completion SHALL be decided by count, not by WLAST: a fire with w_expect_last pops the head and clears the counter in the same edge.
REQ-024 len_error SHALL pulse high for one cycle, in the cycle after any of:
- w_beat_last != w_expect_last on a fire;
- w_beat_fire while w_src_valid is low (the beat is ignored);
- a dropped push.
REQ-025 A push and a pop in the same cycle SHALL keep outstanding_count unchanged and keep the pushed entry's order.
REQ-026 len = 2^LEN_WIDTH-1 SHALL give exactly 2^LEN_WIDTH beats, with no counter overflow.
REQ-027 Read and write pointers SHALL wrap modulo pending_depth; full/empty SHALL be distinguished by an extra pointer bit or by the count.
REQ-028 idle = (outstanding_count == 0).

Reset
REQ-029 ARESETn low SHALL immediately clear the FIFO pointers, count, beat counter and len_error.
- Output values during reset: w_src_valid=0, w_src_master=0, w_expect_last=0, outstanding_count=0, idle=1, aw_push_ready=1.
REQ-030 A reset in the middle of a burst SHALL discard all pending entries; the first push after release starts with beat counter 0.

Verification
REQ-031 Reset check: assert ARESETn=0 mid-simulation, asynchronously to ACLK.
- Required outputs, before the next edge: idle=1, aw_push_ready=1, outstanding_count=0, w_src_valid=0.
REQ-032 Ordering check: push (m1,len3) then (m0,len0).
- Head: w_src_master=1 on the cycle after the first push.
- 4 fires, last with w_beat_last=1: w_expect_last high only on the 4th beat.
- After the 4th fire: w_src_master=0.
- 1 fire: idle=1, with len_error never asserted.
REQ-033 Full and same-cycle check (pending_depth=4): 4 pushes give outstanding_count=4 and aw_push_ready=0.
- A 5th push is dropped and len_error pulses once.
- A same-cycle push plus final-beat pop on a count-3 FIFO leaves the count at 3.
REQ-034 Error check: on head len=2, fire with w_beat_last=1 on beat 1.
- len_error pulses the next cycle.
- The burst still completes after beat 3, and the head pops.
REQ-035 Maximum-length check: masters=4, LEN_WIDTH=4, push (m3,len15).
- Exactly 16 fires pop the entry, with w_src_master=3 throughout.
- A stray fire on the empty FIFO afterwards gives a len_error pulse and no state change.
